// File: rtl/chksum_sched.sv
// chksum_sched: round-robin sharing of one byte-serial checksum datapath between two requesters
module chksum_sched #(
  parameter int MAX_BYTES = 1480,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [16:0] init0,
  input  logic [16:0] init1,
  input  logic        valid0,
  input  logic        valid1,
  input  logic [7:0]  data0,
  input  logic [7:0]  data1,
  input  logic        last0,
  input  logic        last1,
  output logic        ready0,
  output logic        ready1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] result,
  output logic        err,
  output logic        cs_rst,
  output logic [16:0] cs_init,
  output logic        cs_en,
  output logic [7:0]  cs_data,
  input  logic [16:0] cs_cali
);
  typedef enum logic [2:0] {IDLE, LOAD, STREAM, FOLD1, FOLD2, DONE} state_t;
  state_t state;
  logic win, rr, err_r, nxt, valid_g, last_g;
  logic [CNT_W-1:0] cnt;
  logic [16:0] sum_r;
  logic [7:0] data_g;
  logic [15:0] fin;
  always_comb begin
    nxt = (req0 && req1) ? rr : req1;
    valid_g = win ? valid1 : valid0;
    last_g = win ? last1 : last0;
    data_g = win ? data1 : data0;
    fin = sum_r[15:0] + {15'd0, sum_r[16]};
    cs_rst = !rst || state == LOAD;
    cs_init = state == LOAD ? (win ? init1 : init0) : 17'd0;
    cs_en = state == STREAM && valid_g;
    cs_data = state == STREAM ? data_g : 8'd0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      win <= 1'b0;
      rr <= 1'b0;
      cnt <= '0;
      err_r <= 1'b0;
      sum_r <= '0;
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      ready0 <= 1'b0;
      ready1 <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      result <= '0;
      err <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: if (req0 || req1) begin
          win <= nxt;
          rr <= ~nxt;
          gnt0 <= ~nxt;
          gnt1 <= nxt;
          state <= LOAD;
        end
        LOAD: begin
          cnt <= '0;
          ready0 <= ~win;
          ready1 <= win;
          state <= STREAM;
        end
        STREAM: if (valid_g) begin
          cnt <= cnt + 1'b1;
          if (last_g || cnt == CNT_W'(MAX_BYTES - 1)) begin
            err_r <= ~last_g;
            ready0 <= 1'b0;
            ready1 <= 1'b0;
            state <= FOLD1;
          end
        end
        FOLD1: begin
          sum_r <= cs_cali;
          state <= FOLD2;
        end
        FOLD2: begin
          result <= ~fin;
          err <= err_r;
          done0 <= ~win;
          done1 <= win;
          state <= DONE;
        end
        DONE: begin
          gnt0 <= 1'b0;
          gnt1 <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_chksum_sched.sv
// tb_chksum_sched: scoreboard bench for chksum_sched with a behavioural checksum datapath
module tb_chksum_sched;
  localparam int MAXB = 4;
  logic clk = 0, rst = 0;
  logic req0 = 0, req1 = 0, valid0 = 0, valid1 = 0, last0 = 0, last1 = 0;
  logic [16:0] init0 = 0, init1 = 0;
  logic [7:0] data0 = 0, data1 = 0;
  logic ready0, ready1, gnt0, gnt1, done0, done1, err, cs_rst, cs_en;
  logic [15:0] result;
  logic [16:0] cs_init, cs_cali;
  logic [7:0] cs_data;
  logic [16:0] acc;
  logic ph;
  logic [16:0] exp0[$], exp1[$];
  logic ord_q[$];
  logic [7:0] q[$], qa[$], qb[$];
  logic mon_s;
  logic [16:0] mon_e;
  int n_tests = 0, n_fail = 0;

  chksum_sched #(.MAX_BYTES(MAXB), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .init0(init0), .init1(init1),
    .valid0(valid0), .valid1(valid1), .data0(data0), .data1(data1),
    .last0(last0), .last1(last1), .ready0(ready0), .ready1(ready1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .err(err), .cs_rst(cs_rst), .cs_init(cs_init),
    .cs_en(cs_en), .cs_data(cs_data), .cs_cali(cs_cali)
  );

  always #5 clk = ~clk;

  // External datapath: high byte first, end-around carry folded on each add
  assign cs_cali = acc;
  always @(posedge clk) begin
    if (cs_rst) begin
      acc <= cs_init;
      ph <= 1'b0;
    end else if (cs_en) begin
      acc <= {1'b0, acc[15:0]} + {16'd0, acc[16]} + (ph ? {9'd0, cs_data} : {1'b0, cs_data, 8'd0});
      ph <= ~ph;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] ref_cs(input logic [16:0] ini, input logic [7:0] b[$], input int n, input bit e);
    int unsigned s;
    s = 32'(ini);
    for (int i = 0; i < n; i++) s += (i % 2 == 0) ? (32'(b[i]) << 8) : 32'(b[i]);
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    return {e, ~s[15:0]};
  endfunction

  task automatic drive(input bit s, input logic r, input logic v, input logic [7:0] d, input logic l);
    if (s) begin
      req1 = r; valid1 = v; data1 = d; last1 = l;
    end else begin
      req0 = r; valid0 = v; data0 = d; last0 = l;
    end
  endtask

  task automatic run_job(input bit s, input logic [16:0] ini, input logic [7:0] b[$], input bit use_last);
    int n;
    bit ok;
    n = use_last ? b.size() : (b.size() < MAXB ? b.size() : MAXB);
    if (s) begin
      exp1.push_back(ref_cs(ini, b, n, !use_last));
      init1 = ini;
    end else begin
      exp0.push_back(ref_cs(ini, b, n, !use_last));
      init0 = ini;
    end
    for (int i = 0; i < n; i++) begin
      drive(s, 1'b1, 1'b1, b[i], use_last && i == n - 1);
      ok = 0;
      for (int k = 0; k < 100 && !ok; k++) begin
        @(negedge clk);
        ok = s ? ready1 : ready0;
        @(posedge clk);
      end
      #1;
      if (!ok) begin
        chk("accept_timeout", 0, 1);
        drive(s, 1'b0, 1'b0, 8'h00, 1'b0);
        return;
      end
    end
    if (n < b.size()) drive(s, 1'b1, 1'b1, b[n], 1'b0);
    else drive(s, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      chk("latency", {30'd0, s ? ready1 : ready0, s ? done1 : done0}, {30'd0, 1'b0, j == 3});
    end
    drive(s, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("invariant", {24'd0, gnt0 & gnt1, done0 & done1, ready0 & ~gnt0, ready1 & ~gnt1,
          done0 & ~gnt0, done1 & ~gnt1,
          cs_en != ((gnt0 & valid0 & ready0) | (gnt1 & valid1 & ready1)),
          cs_en && cs_data != (gnt1 ? data1 : data0)}, 0);
      if (done0 || done1) begin
        mon_s = done1;
        if (ord_q.size() != 0) chk("order", {31'd0, mon_s}, {31'd0, ord_q.pop_front()});
        if (mon_s ? exp1.size() == 0 : exp0.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          mon_e = mon_s ? exp1.pop_front() : exp0.pop_front();
          chk(mon_s ? "result1" : "result0", {16'd0, result}, {16'd0, mon_e[15:0]});
          chk(mon_s ? "err1" : "err0", {31'd0, err}, {31'd0, mon_e[16]});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {24'd0, gnt0, gnt1, ready0, ready1, done0, done1, err, cs_en}, 0);
    chk("rst_result", {16'd0, result}, 0);
    chk("rst_csrst", {31'd0, cs_rst}, 1);
    chk("rst_cs_init", {15'd0, cs_init}, 0);
    chk("rst_cs_data", {24'd0, cs_data}, 0);
    rst = 1;
    @(negedge clk);
    chk("idle_csrst", {31'd0, cs_rst}, 0);
    q = '{8'h45, 8'h00, 8'h00, 8'h1C};
    run_job(0, 17'h00000, q, 1);
    q = '{8'hFF, 8'hFF};
    run_job(0, 17'h0FFFF, q, 1);
    q = '{8'h12, 8'h34, 8'h56};
    run_job(1, 17'h00000, q, 1);
    q = '{8'h00, 8'h01};
    run_job(1, 17'h0FFFF, q, 1);
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_job(0, 17'h00000, q, 0);
    // Abort a req1 job mid-stream; no done may follow and the next job must be clean
    req1 = 1; init1 = 17'h01234; valid1 = 1; data1 = 8'hAA; last1 = 0;
    begin
      bit ok;
      ok = 0;
      for (int k = 0; k < 20 && !ok; k++) begin
        @(negedge clk);
        ok = ready1;
      end
      chk("mid_ready", {31'd0, ok}, 1);
    end
    @(posedge clk);
    #1 data1 = 8'h55;
    @(negedge clk);
    rst = 0;
    #1 chk("mid_csrst", {31'd0, cs_rst}, 1);
    @(posedge clk);
    #1 chk("mid_clear", {26'd0, gnt0, gnt1, ready0, ready1, done0, done1}, 0);
    req1 = 0; valid1 = 0; data1 = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    ord_q.push_back(0); ord_q.push_back(1); ord_q.push_back(0); ord_q.push_back(1);
    fork
      begin
        qa = '{8'h01, 8'h02};
        run_job(0, 17'h00000, qa, 1);
        qa = '{8'hFF};
        run_job(0, 17'h1ABCD, qa, 1);
      end
      begin
        qb = '{8'h10, 8'h20, 8'h30};
        run_job(1, 17'h00100, qb, 1);
        qb = '{8'h80, 8'h00, 8'h80, 8'h00};
        run_job(1, 17'h00000, qb, 1);
      end
    join
    repeat (3) @(negedge clk);
    chk("sb_left", exp0.size() + exp1.size() + ord_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
